// File: rtl/eth_rx_deframer.sv
// eth_rx_deframer
//   Pulls length-prefixed frames out of a first-word-fall-through RX FIFO
//   and presents them as a valid/ready/last byte stream. Frames with a
//   zero length or a length above MAX_LEN are consumed and discarded.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   rx_empty_i, rx_data_i  FIFO status and head byte
//   rx_reset_i             FIFO content lost; aborts the current frame
//   rx_rd_en_o             FIFO pop (combinational)
//   m_t*                   output byte stream, single register stage
//   len_valid_o, len_o     one-cycle pulse with accepted frame length
//   abort_o                one-cycle pulse when a frame is cut off
//   pkt_count_o            frames fully delivered (wraps)
//   drop_count_o           frames discarded for bad length (wraps)
module eth_rx_deframer #(
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_empty_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_reset_i,
  output logic             rx_rd_en_o,
  output logic             m_tvalid_o,
  output logic [7:0]       m_tdata_o,
  output logic             m_tlast_o,
  input  logic             m_tready_i,
  output logic             len_valid_o,
  output logic [15:0]      len_o,
  output logic             abort_o,
  output logic [CNT_W-1:0] pkt_count_o,
  output logic [CNT_W-1:0] drop_count_o
);

  typedef enum logic [2:0] {LEN_HI, LEN_LO, CHECK, DATA, DROP} state_t;

  localparam logic [15:0]      MaxLen = 16'(MAX_LEN);
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      rem_q, rem_d;
  logic             tvalid_q, tvalid_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tlast_q, tlast_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             rd_en;
  logic             len_valid;
  logic             abort;
  logic             handshake;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= LEN_HI;
      len_q    <= '0;
      rem_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      pkt_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      pkt_q    <= pkt_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rem_d     = rem_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    pkt_d     = pkt_q;
    drop_d    = drop_q;
    rd_en     = 1'b0;
    len_valid = 1'b0;
    abort     = 1'b0;

    // A byte leaving the output register is delivered even if the FIFO
    // reports content loss in the same cycle.
    handshake = tvalid_q & m_tready_i;
    if (handshake) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      if (tlast_q) pkt_d = pkt_q + CntOne;
    end

    if (rx_reset_i) begin
      state_d  = LEN_HI;
      rem_d    = '0;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      abort    = (state_q == DATA) || tvalid_q;
    end else begin
      unique case (state_q)
        LEN_HI: if (!rx_empty_i) begin
          rd_en        = 1'b1;
          len_d[15:8]  = rx_data_i;
          state_d      = LEN_LO;
        end
        LEN_LO: if (!rx_empty_i) begin
          rd_en       = 1'b1;
          len_d[7:0]  = rx_data_i;
          state_d     = CHECK;
        end
        CHECK: begin
          rem_d = len_q;
          if ((len_q == 16'd0) || (len_q > MaxLen)) begin
            drop_d  = drop_q + CntOne;
            state_d = (len_q == 16'd0) ? LEN_HI : DROP;
          end else begin
            len_valid = 1'b1;
            state_d   = DATA;
          end
        end
        DATA: if (!rx_empty_i && (!tvalid_q || m_tready_i)) begin
          // Load overrides the drain above, so load+drain keeps valid high.
          rd_en    = 1'b1;
          tvalid_d = 1'b1;
          tdata_d  = rx_data_i;
          tlast_d  = (rem_q == 16'd1);
          rem_d    = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = LEN_HI;
        end
        DROP: if (!rx_empty_i) begin
          rd_en = 1'b1;
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = LEN_HI;
        end
        default: state_d = LEN_HI;
      endcase
    end
  end

  assign rx_rd_en_o   = rd_en;
  assign m_tvalid_o   = tvalid_q;
  assign m_tdata_o    = tdata_q;
  assign m_tlast_o    = tlast_q;
  assign len_valid_o  = len_valid;
  assign len_o        = len_valid ? len_q : '0;
  assign abort_o      = abort;
  assign pkt_count_o  = pkt_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_eth_rx_deframer.sv
module tb_eth_rx_deframer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        rx_empty_i;
  logic [7:0]  rx_data_i;
  logic        rx_reset_i;
  logic        rx_rd_en_o;
  logic        m_tvalid_o;
  logic [7:0]  m_tdata_o;
  logic        m_tlast_o;
  logic        m_tready_i;
  logic        len_valid_o;
  logic [15:0] len_o;
  logic        abort_o;
  logic [15:0] pkt_count_o;
  logic [15:0] drop_count_o;

  eth_rx_deframer #(.MAX_LEN(1518), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .rx_empty_i(rx_empty_i), .rx_data_i(rx_data_i),
    .rx_reset_i(rx_reset_i), .rx_rd_en_o(rx_rd_en_o), .m_tvalid_o(m_tvalid_o),
    .m_tdata_o(m_tdata_o), .m_tlast_o(m_tlast_o), .m_tready_i(m_tready_i),
    .len_valid_o(len_valid_o), .len_o(len_o), .abort_o(abort_o),
    .pkt_count_o(pkt_count_o), .drop_count_o(drop_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] hdr;
    int unsigned n;
    int unsigned stall;
    logic        acc;
    logic [7:0]  seed;
  } vec_t;

  logic [7:0]  fifo[$];
  logic [7:0]  cap_d[$];
  logic        cap_l[$];
  int unsigned rd_cnt, lv_cnt, ab_cnt, tv_cnt;
  logic [15:0] len_cap;
  logic        pend;
  int unsigned n_pass = 0, n_total = 0;
  int unsigned exp_pkt = 0, exp_drop = 0;

  task automatic refresh();
    rx_empty_i = (fifo.size() == 0);
    rx_data_i  = (fifo.size() == 0) ? 8'h00 : fifo[0];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic clr_mon();
    cap_d.delete(); cap_l.delete();
    rd_cnt = 0; lv_cnt = 0; ab_cnt = 0; tv_cnt = 0; len_cap = '0;
  endtask

  // Monitor and FIFO model: sample late in the cycle, pop just after the edge.
  always begin
    @(negedge clk); #3;
    if (m_tvalid_o && m_tready_i) begin
      cap_d.push_back(m_tdata_o);
      cap_l.push_back(m_tlast_o);
    end
    if (m_tvalid_o) tv_cnt++;
    if (rx_rd_en_o) rd_cnt++;
    if (len_valid_o) begin lv_cnt++; len_cap = len_o; end
    if (abort_o) ab_cnt++;
    pend = rx_rd_en_o;
    @(posedge clk); #1;
    if (pend && fifo.size() > 0) fifo.delete(0);
    refresh();
  end

  task automatic wait_idle(input int unsigned budget, input string nm);
    int unsigned c = 0;
    while (!(fifo.size() == 0 && !m_tvalid_o) && c < budget) begin
      @(posedge clk); #1; c++;
    end
    if (c >= budget) chk({nm, "_timeout"}, c, 0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic run_frame(input vec_t v, input string nm);
    logic [7:0]  pl[$];
    int unsigned c, rd0, bad, lbad;
    clr_mon();
    for (int unsigned i = 0; i < v.n; i++) pl.push_back(8'(v.seed + 8'h11 * i));
    fifo.push_back(v.hdr[15:8]);
    fifo.push_back(v.hdr[7:0]);
    foreach (pl[i]) fifo.push_back(pl[i]);
    refresh();
    m_tready_i = 1'b1;
    if (v.stall > 0) begin
      c = 0;
      while (cap_d.size() < 1 && c < 50) begin @(posedge clk); #1; c++; end
      chk({nm, "_first"}, cap_d.size(), 1);
      m_tready_i = 1'b0;
      rd0 = rd_cnt;
      repeat (v.stall) begin
        @(posedge clk); #2;
        chk({nm, "_hold"}, {m_tvalid_o, m_tdata_o}, {1'b1, pl[1]});
      end
      chk({nm, "_nopop"}, rd_cnt, rd0);
      m_tready_i = 1'b1;
    end
    wait_idle(v.n + 200, nm);
    if (v.acc) exp_pkt++; else exp_drop++;
    chk({nm, "_pops"}, rd_cnt, v.n + 2);
    chk({nm, "_nout"}, cap_d.size(), v.acc ? v.n : 0);
    chk({nm, "_tvcyc"}, tv_cnt, v.acc ? v.n + v.stall : 0);
    chk({nm, "_lvcnt"}, lv_cnt, v.acc ? 1 : 0);
    if (v.acc) chk({nm, "_len"}, len_cap, v.hdr);
    chk({nm, "_pkt"}, pkt_count_o, exp_pkt);
    chk({nm, "_drop"}, drop_count_o, exp_drop);
    if (v.acc && cap_d.size() == v.n) begin
      bad = 0; lbad = 0;
      foreach (pl[i]) begin
        if (cap_d[i] !== pl[i]) bad++;
        if (cap_l[i] !== (i == v.n - 1)) lbad++;
      end
      chk({nm, "_data"}, bad, 0);
      chk({nm, "_last"}, lbad, 0);
    end
  endtask

  vec_t vt[8];

  initial begin
    int unsigned c;
    vt[0] = '{16'd3,    3,    0, 1'b1, 8'hAA};
    vt[1] = '{16'd3,    3,    4, 1'b1, 8'hAA};
    vt[2] = '{16'd2000, 2000, 0, 1'b0, 8'h3C};
    vt[3] = '{16'd1,    1,    0, 1'b1, 8'h55};
    vt[4] = '{16'd0,    0,    0, 1'b0, 8'h00};
    vt[5] = '{16'd2,    2,    0, 1'b1, 8'h11};
    vt[6] = '{16'd1518, 1518, 0, 1'b1, 8'h01};
    vt[7] = '{16'd1519, 1519, 0, 1'b0, 8'h02};

    rst_ni = 1'b0; rx_reset_i = 1'b0; m_tready_i = 1'b0;
    refresh();
    #2;
    chk("rst_outs", {rx_rd_en_o, m_tvalid_o, m_tdata_o, m_tlast_o, len_valid_o, len_o, abort_o}, '0);
    chk("rst_cnts", {pkt_count_o, drop_count_o}, '0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_frame(vt[i], $sformatf("vec%0d", i));

    // Content loss after the second byte of a four-byte frame is delivered.
    clr_mon();
    fifo = '{8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
    refresh();
    m_tready_i = 1'b1;
    c = 0;
    do begin @(posedge clk); #2; c++; end
    while (!(m_tvalid_o && m_tdata_o == 8'h02) && c < 50);
    chk("abt_reach", c < 50, 1);
    rx_reset_i = 1'b1;
    #1;
    chk("abt_pulse", abort_o, 1);
    chk("abt_nopop", rx_rd_en_o, 0);
    @(posedge clk); #1;
    rx_reset_i = 1'b0;
    fifo.delete();
    refresh();
    chk("abt_clr", {m_tvalid_o, m_tlast_o, abort_o}, 3'b000);
    fifo = '{8'h00, 8'h01, 8'h77};
    refresh();
    wait_idle(100, "abt");
    exp_pkt++;
    chk("abt_count", ab_cnt, 1);
    chk("abt_nout", cap_d.size(), 3);
    if (cap_d.size() == 3) begin
      chk("abt_bytes", {cap_d[0], cap_d[1], cap_d[2]}, 24'h010277);
      chk("abt_lasts", {cap_l[0], cap_l[1], cap_l[2]}, 3'b001);
    end
    chk("abt_pkt", pkt_count_o, exp_pkt);
    chk("abt_drop", drop_count_o, exp_drop);

    // Asynchronous reset while a byte is held in the output register.
    clr_mon();
    m_tready_i = 1'b0;
    fifo = '{8'h00, 8'h02, 8'hA1, 8'hA2};
    refresh();
    c = 0;
    while (!m_tvalid_o && c < 20) begin @(posedge clk); #1; c++; end
    chk("ar_valid", {m_tvalid_o, m_tdata_o}, {1'b1, 8'hA1});
    #1 rst_ni = 1'b0;
    #1;
    chk("ar_outs", {m_tvalid_o, m_tdata_o, m_tlast_o, len_valid_o, len_o, abort_o}, '0);
    chk("ar_cnts", {pkt_count_o, drop_count_o}, '0);
    @(posedge clk); #1;
    fifo.delete();
    refresh();
    exp_pkt = 0; exp_drop = 0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    run_frame('{16'd1, 1, 0, 1'b1, 8'h5A}, "ar_after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
